bram_burst_reader: RTL and testbench

- Fills the instruction cache on a miss.
- On an arbiter request, issues BURST_LEN consecutive word reads to the BRAM and streams the returned words to the cache as a fixed-length valid-qualified burst (data_out/data_valid feed the cache's bram_data_in/bram_in_valid).
- Sits between the arbiter and the BRAM macro.
- The cache has no backpressure, so the stream is never stalled once started.

---
 rtl/burst_pkg.sv | 16 +
 rtl/rd_lat_pipe.sv | 27 ++
 rtl/bram_burst_reader.sv | 135 +++++++++++++
 tb/tb_bram_burst_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared definitions for the BRAM burst reader that refills the instruction cache.
// Holds the FSM encoding, the default burst length and the byte/word address shift.
package burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Matches the instruction cache's CPU refill burst length.
    localparam int DEFAULT_BURST_LEN = 8;

    localparam int BYTE_SHIFT = 2;

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid-tracking shift register that mirrors the BRAM read latency.
// The tail is high in the same cycle that the BRAM presents the data for an earlier read enable.
module rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tail
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stages <= '0;
        end else begin
            stages[0] <= en;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tail = stages[DEPTH-1];

endmodule

// File: rtl/bram_burst_reader.sv
// Reads BURST_LEN consecutive BRAM words on an arbiter request and streams them to the
// instruction cache as a contiguous valid-qualified burst; the cache cannot stall the stream.
module bram_burst_reader
    import burst_pkg::*;
#(
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int ADDR_W    = 12,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [31:0]       bram_rdata,
    output logic [31:0]       data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    if (BURST_LEN < 2 || BURST_LEN > 16 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst_len
        $fatal(1, "bram_burst_reader: BURST_LEN must be a power of two in 2..16");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $fatal(1, "bram_burst_reader: RD_LAT must be in 1..4");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
        $fatal(1, "bram_burst_reader: ADDR_W must be in 1..29");
    end

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic              issue_last;
    logic              pipe_tail;
    logic              accept;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:ADDR_W+BYTE_SHIFT], req_addr[BYTE_SHIFT-1:0]};

    assign issue_last = (issue_cnt == LAST_CNT);
    assign accept     = req_valid && req_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        bram_en    = 1'b0;
        bram_addr  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                bram_en   = 1'b1;
                bram_addr = start_addr + ADDR_W'(issue_cnt);
                if (issue_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only after the final word has gone out, so busy covers it.
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            start_addr <= '0;
            issue_cnt  <= '0;
        end else begin
            if (accept) begin
                start_addr <= req_addr[ADDR_W+BYTE_SHIFT-1:BYTE_SHIFT];
            end
            if (state == ISSUE) begin
                issue_cnt <= issue_last ? '0 : issue_cnt + CNT_W'(1);
            end
        end
    end

    rd_lat_pipe #(
        .DEPTH(RD_LAT)
    ) u_rd_lat_pipe (
        .clk (clk),
        .rst (rst),
        .en  (bram_en),
        .tail(pipe_tail)
    );

    // Output register: data_out keeps its last word between bursts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            out_cnt    <= '0;
        end else begin
            data_valid <= pipe_tail;
            done       <= pipe_tail && (out_cnt == LAST_CNT);
            if (pipe_tail) begin
                data_out <= bram_rdata;
                out_cnt  <= (out_cnt == LAST_CNT) ? '0 : out_cnt + CNT_W'(1);
            end
        end
    end

    a_done_with_valid : assert property (@(posedge clk) disable iff (!rst) done |-> data_valid);
    a_en_only_busy    : assert property (@(posedge clk) disable iff (!rst) bram_en |-> busy);

endmodule

// File: tb/tb_bram_burst_reader.sv
// Self-checking bench for bram_burst_reader: two instances (RD_LAT 1 and 3) with BRAM models,
// a scoreboard queue of expected words, and one task per scenario.
module tb_bram_burst_reader;

    localparam int BL    = 8;
    localparam int AW    = 12;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic [31:0]   req_addr = 32'h0;
    logic          sel = 1'b0;

    logic          rdy_a, en_a, dv_a, busy_a, done_a;
    logic [AW-1:0] addr_a;
    logic [31:0]   rdata_a, dout_a;
    logic          rdy_b, en_b, dv_b, busy_b, done_b;
    logic [AW-1:0] addr_b;
    logic [31:0]   rdata_b, dout_b;

    logic          o_rdy, o_en, o_dv, o_busy, o_done;
    logic [AW-1:0] o_addr;
    logic [31:0]   o_dout;

    int            checks = 0;
    int            errors = 0;
    int            dv_seen = 0;
    logic [31:0]   exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {4'hB, a, 4'h7, ~a};
    endfunction

    // BRAM models: registered output, RD_LAT stages deep.
    logic [31:0] sa0 = 32'h0;
    logic [31:0] sb0 = 32'h0;
    logic [31:0] sb1 = 32'h0;
    logic [31:0] sb2 = 32'h0;

    always @(posedge clk) begin
        if (en_a) sa0 <= mem_word(addr_a);
        if (en_b) sb0 <= mem_word(addr_b);
        sb1 <= sb0;
        sb2 <= sb1;
    end

    assign rdata_a = sa0;
    assign rdata_b = sb2;

    bram_burst_reader #(.BURST_LEN(BL), .ADDR_W(AW), .RD_LAT(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_addr(req_addr),
        .req_ready(rdy_a), .bram_en(en_a), .bram_addr(addr_a), .bram_rdata(rdata_a),
        .data_out(dout_a), .data_valid(dv_a), .busy(busy_a), .done(done_a)
    );

    bram_burst_reader #(.BURST_LEN(BL), .ADDR_W(AW), .RD_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_addr(req_addr),
        .req_ready(rdy_b), .bram_en(en_b), .bram_addr(addr_b), .bram_rdata(rdata_b),
        .data_out(dout_b), .data_valid(dv_b), .busy(busy_b), .done(done_b)
    );

    assign o_rdy  = sel ? rdy_b  : rdy_a;
    assign o_en   = sel ? en_b   : en_a;
    assign o_addr = sel ? addr_b : addr_a;
    assign o_dv   = sel ? dv_b   : dv_a;
    assign o_dout = sel ? dout_b : dout_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;

    // Scoreboard: every delivered word must be the next expected one.
    always @(negedge clk) begin
        if (o_dv) begin
            dv_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected_word got=%h expected=none", o_dout);
            end else begin
                logic [31:0] exp_w;
                exp_w = exp_q.pop_front();
                if (o_dout !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL sb_word got=%h expected=%h", o_dout, exp_w);
                end
            end
        end
    end

    task automatic push_burst(input logic [31:0] a);
        logic [AW-1:0] w;
        w = a[AW+1:2];
        for (int i = 0; i < BL; i++) begin
            exp_q.push_back(mem_word(w));
            w = w + 1'b1;
        end
    endtask

    // Presents a request in IDLE; returns just after the accepting edge (edge 0).
    task automatic start_burst(input logic [31:0] a);
        @(negedge clk);
        req_addr  = a;
        req_valid = 1'b1;
        push_burst(a);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (o_rdy  !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got=%b expected=1", o_rdy); end
        checks++; if (o_en   !== 1'b0) begin errors++; $display("[TB] FAIL reset_bram_en got=%b expected=0", o_en); end
        checks++; if (o_addr !== '0)   begin errors++; $display("[TB] FAIL reset_bram_addr got=%h expected=0", o_addr); end
        checks++; if (o_dout !== '0)   begin errors++; $display("[TB] FAIL reset_data_out got=%h expected=0", o_dout); end
        checks++; if (o_dv   !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_valid got=%b expected=0", o_dv); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b expected=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b expected=0", o_done); end
        rst = 1'b1;
    endtask

    task automatic test_basic;
        logic [AW-1:0] ea;
        logic exp_en, exp_dv;
        sel = 1'b0;
        start_burst(32'h0000_0040);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp_en = (c >= 1 && c <= 8);
            exp_dv = (c >= 3 && c <= 10);
            checks++; if (o_en !== exp_en) begin errors++; $display("[TB] FAIL basic_en cyc=%0d got=%b expected=%b", c, o_en, exp_en); end
            if (exp_en) begin
                ea = AW'(32'h10 + c - 1);
                checks++; if (o_addr !== ea) begin errors++; $display("[TB] FAIL basic_addr cyc=%0d got=%h expected=%h", c, o_addr, ea); end
            end
            checks++; if (o_dv !== exp_dv) begin errors++; $display("[TB] FAIL basic_valid cyc=%0d got=%b expected=%b", c, o_dv, exp_dv); end
            checks++; if (o_done !== (c == 10)) begin errors++; $display("[TB] FAIL basic_done cyc=%0d got=%b expected=%b", c, o_done, (c == 10)); end
            checks++; if (o_busy !== (c <= 10)) begin errors++; $display("[TB] FAIL basic_busy cyc=%0d got=%b expected=%b", c, o_busy, (c <= 10)); end
            checks++; if (o_rdy !== (c >= 11)) begin errors++; $display("[TB] FAIL basic_ready cyc=%0d got=%b expected=%b", c, o_rdy, (c >= 11)); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL basic_words_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] ea;
        sel = 1'b0;
        start_burst(32'h0000_3FF8);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                ea = AW'(32'hFFE + c - 1);
                checks++; if (o_en !== 1'b1) begin errors++; $display("[TB] FAIL wrap_en cyc=%0d got=%b expected=1", c, o_en); end
                checks++; if (o_addr !== ea) begin errors++; $display("[TB] FAIL wrap_addr cyc=%0d got=%h expected=%h", c, o_addr, ea); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL wrap_words_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_ignore_mid_burst;
        int en_cnt = 0;
        int dv_cnt = 0;
        sel = 1'b0;
        start_burst(32'h0000_0200);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (o_en) en_cnt++;
            if (o_dv) dv_cnt++;
            if (c == 4) begin
                checks++; if (o_rdy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_ready got=%b expected=0", o_rdy); end
                req_addr  = 32'h0000_0100;
                req_valid = 1'b1;
            end
            if (c == 5) req_valid = 1'b0;
        end
        checks++; if (en_cnt != BL) begin errors++; $display("[TB] FAIL ignore_en_count got=%0d expected=%0d", en_cnt, BL); end
        checks++; if (dv_cnt != BL) begin errors++; $display("[TB] FAIL ignore_valid_count got=%0d expected=%0d", dv_cnt, BL); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL ignore_words_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_rd_lat3;
        logic exp_dv;
        sel = 1'b1;
        start_burst(32'h0000_0000);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            exp_dv = (c >= LAT_B + 2 && c <= LAT_B + 9);
            checks++; if (o_en !== (c <= 8)) begin errors++; $display("[TB] FAIL lat3_en cyc=%0d got=%b expected=%b", c, o_en, (c <= 8)); end
            checks++; if (o_dv !== exp_dv) begin errors++; $display("[TB] FAIL lat3_valid cyc=%0d got=%b expected=%b", c, o_dv, exp_dv); end
            checks++; if (o_done !== (c == LAT_B + 9)) begin errors++; $display("[TB] FAIL lat3_done cyc=%0d got=%b expected=%b", c, o_done, (c == LAT_B + 9)); end
            checks++; if (o_busy !== (c <= LAT_B + 9)) begin errors++; $display("[TB] FAIL lat3_busy cyc=%0d got=%b expected=%b", c, o_busy, (c <= LAT_B + 9)); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL lat3_words_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_burst;
        int dv_cnt = 0;
        sel = 1'b1;
        start_burst(32'h0000_0080);
        for (int c = 1; c <= 5; c++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (o_rdy  !== 1'b1) begin errors++; $display("[TB] FAIL midrst_req_ready got=%b expected=1", o_rdy); end
        checks++; if (o_en   !== 1'b0) begin errors++; $display("[TB] FAIL midrst_bram_en got=%b expected=0", o_en); end
        checks++; if (o_addr !== '0)   begin errors++; $display("[TB] FAIL midrst_bram_addr got=%h expected=0", o_addr); end
        checks++; if (o_dout !== '0)   begin errors++; $display("[TB] FAIL midrst_data_out got=%h expected=0", o_dout); end
        checks++; if (o_dv   !== 1'b0) begin errors++; $display("[TB] FAIL midrst_data_valid got=%b expected=0", o_dv); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b expected=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got=%b expected=0", o_done); end
        rst = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (o_dv) dv_cnt++;
        end
        checks++; if (dv_cnt != 0) begin errors++; $display("[TB] FAIL midrst_late_valid got=%0d expected=0", dv_cnt); end
    endtask

    task automatic test_back_to_back;
        int  n = 0;
        int  gap = 0;
        int  gaps_checked = 0;
        int  dv0;
        bit  pending = 0;
        bit  seen_en = 0;
        sel = 1'b0;
        dv0 = dv_seen;
        @(negedge clk);
        req_addr  = 32'h0000_1000;
        req_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (pending) begin
                pending  = 0;
                req_addr = req_addr + 32'h40;
                if (n == 3) req_valid = 1'b0;
            end
            if (req_valid && o_rdy) begin
                push_burst(req_addr);
                n++;
                pending = 1;
            end
            if (o_en) begin
                if (seen_en && gap > 0) begin
                    gaps_checked++;
                    checks++; if (gap != LAT_A + 2) begin errors++; $display("[TB] FAIL b2b_gap got=%0d expected=%0d", gap, LAT_A + 2); end
                end
                seen_en = 1;
                gap = 0;
            end else if (seen_en) begin
                gap++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (n != 3) begin errors++; $display("[TB] FAIL b2b_accepts got=%0d expected=3", n); end
        checks++; if (gaps_checked != 2) begin errors++; $display("[TB] FAIL b2b_gap_count got=%0d expected=2", gaps_checked); end
        checks++; if (dv_seen - dv0 != 3 * BL) begin errors++; $display("[TB] FAIL b2b_words got=%0d expected=%0d", dv_seen - dv0, 3 * BL); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_words_left got=%0d expected=0", exp_q.size()); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_mid_burst();
        test_rd_lat3();
        test_reset_mid_burst();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
